// File: rtl/block_serializer_64x8.sv
// Serializes a packed 8x8 block (element 0 in the MSBs) into one byte per
// output handshake, in raster or JPEG zig-zag order, with bubble-free block chaining.
module block_serializer_64x8 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ZIGZAG     = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*DEPTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [5:0]                  out_index,
  output logic                        out_last,
  output logic [15:0]                 out_block_cnt
);

  localparam int unsigned BLOCK_W  = DATA_WIDTH * DEPTH;
  localparam logic [5:0]  LAST_IDX = 6'(DEPTH - 1);

  // Standard JPEG zig-zag scan: output position k -> raster element index.
  localparam int unsigned ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t               state;
  logic [BLOCK_W-1:0]   block;
  logic [5:0]           k;
  logic [5:0]           sel;
  logic [DATA_WIDTH-1:0] elems [DEPTH];
  logic                 out_hs;
  logic                 in_hs;

  // Unpack the held block so element 0 comes from the top bits.
  always_comb begin
    for (int e = 0; e < int'(DEPTH); e++) begin
      elems[e] = block[DATA_WIDTH*(DEPTH-e)-1 -: DATA_WIDTH];
    end
  end

  always_comb begin
    sel       = (ZIGZAG != 0) ? 6'(ZZ[k]) : k;
    out_valid = (state == STREAM);
    out_data  = elems[sel];
    out_index = k;
    out_last  = out_valid && (k == LAST_IDX);
    out_hs    = out_valid && out_ready;
    // A new block may enter on the same edge the last byte leaves.
    in_ready  = (state == IDLE) || (out_hs && out_last);
    in_hs     = in_valid && in_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      block         <= '0;
      k             <= '0;
      out_block_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            block <= in_data;
            k     <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (out_hs) begin
            if (k == LAST_IDX) begin
              out_block_cnt <= out_block_cnt + 16'd1;
              if (in_hs) begin
                block <= in_data;
                k     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              k <= k + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_serializer_64x8.sv
// Drives a raster and a zig-zag serializer with identical stimulus and checks
// both against a block/byte-queue reference model every cycle.
module tb_block_serializer_64x8;

  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned BW = DW * DEPTH;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] in_data = '0;

  logic          r_in_ready, r_out_valid, r_out_last;
  logic [DW-1:0] r_out_data;
  logic [5:0]    r_out_index;
  logic [15:0]   r_out_block_cnt;
  logic          z_in_ready, z_out_valid, z_out_last;
  logic [DW-1:0] z_out_data;
  logic [5:0]    z_out_index;
  logic [15:0]   z_out_block_cnt;

  block_serializer_64x8 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ZIGZAG(0)) dut_r (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_data(in_data), .out_valid(r_out_valid), .out_ready(out_ready),
    .out_data(r_out_data), .out_index(r_out_index), .out_last(r_out_last),
    .out_block_cnt(r_out_block_cnt)
  );

  block_serializer_64x8 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ZIGZAG(1)) dut_z (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_data(in_data), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_data(z_out_data), .out_index(z_out_index), .out_last(z_out_last),
    .out_block_cnt(z_out_block_cnt)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: the held block, the next output position, completed blocks.
  int          zz [64];
  logic [BW-1:0] cur = '0;
  bit          held = 1'b0;
  int          pos = 0;
  logic [15:0] cnt = '0;

  function automatic logic [DW-1:0] elem(input logic [BW-1:0] b, input int e);
    return b[BW-1-e*DW -: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic step(input bit iv, input logic [BW-1:0] d, input bit ordy);
    bit exp_ir, out_hs, in_hs;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clock);
    exp_ir = !held || (ordy && pos == 63);
    chk("r_out_valid", 64'(r_out_valid), 64'(held));
    chk("z_out_valid", 64'(z_out_valid), 64'(held));
    chk("r_in_ready", 64'(r_in_ready), 64'(exp_ir));
    chk("z_in_ready", 64'(z_in_ready), 64'(exp_ir));
    chk("r_block_cnt", 64'(r_out_block_cnt), 64'(cnt));
    chk("z_block_cnt", 64'(z_out_block_cnt), 64'(cnt));
    if (held) begin
      chk("r_out_data", 64'(r_out_data), 64'(elem(cur, pos)));
      chk("z_out_data", 64'(z_out_data), 64'(elem(cur, zz[pos])));
      chk("r_out_index", 64'(r_out_index), 64'(pos));
      chk("z_out_index", 64'(z_out_index), 64'(pos));
      chk("r_out_last", 64'(r_out_last), 64'(pos == 63));
      chk("z_out_last", 64'(z_out_last), 64'(pos == 63));
    end
    out_hs = held && ordy;
    in_hs  = iv && exp_ir;
    @(posedge clock);
    if (out_hs) begin
      if (pos == 63) begin
        cnt  = cnt + 16'd1;
        held = 1'b0;
      end else begin
        pos++;
      end
    end
    if (in_hs) begin
      cur  = d;
      pos  = 0;
      held = 1'b1;
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r_valid"}, 64'(r_out_valid), 64'd0);
    chk({tag, "_z_valid"}, 64'(z_out_valid), 64'd0);
    chk({tag, "_r_ready"}, 64'(r_in_ready), 64'd1);
    chk({tag, "_r_cnt"}, 64'(r_out_block_cnt), 64'd0);
    chk({tag, "_z_cnt"}, 64'(z_out_block_cnt), 64'd0);
    chk({tag, "_r_data"}, 64'(r_out_data), 64'd0);
    chk({tag, "_z_data"}, 64'(z_out_data), 64'd0);
    chk({tag, "_r_index"}, 64'(r_out_index), 64'd0);
    chk({tag, "_r_last"}, 64'(r_out_last), 64'd0);
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < int'(BW / 32); i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Run until the model is idle, with a fixed out_ready pattern; a blown budget counts as a failure.
  task automatic drain(input int budget, input bit pattern_bp);
    int c;
    logic [3:0] pat;
    pat = 4'b1001;
    c = 0;
    while (held && c < budget) begin
      step(1'b0, rand_block(), pattern_bp ? pat[c % 4] : 1'b1);
      c++;
    end
    chk("drain_timeout", 64'(held), 64'd0);
  endtask

  initial begin
    logic [BW-1:0] blk_a, blk_b;
    int c;

    // Zig-zag table from the diagonal walk of an 8x8 grid.
    c = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int row = (s < 7 ? s : 7); row >= (s > 7 ? s - 7 : 0); row--) begin
          zz[c] = row * 8 + (s - row);
          c++;
        end
      end else begin
        for (int row = (s > 7 ? s - 7 : 0); row <= (s < 7 ? s : 7); row++) begin
          zz[c] = row * 8 + (s - row);
          c++;
        end
      end
    end

    @(posedge clock);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Raster test block: element e = e + 0x10.
    for (int e = 0; e < 64; e++) blk_a[BW-1-e*DW -: DW] = 8'(e + 16);
    step(1'b1, blk_a, 1'b1);
    drain(80, 1'b0);
    step(1'b0, '0, 1'b1);

    // Identity block: element e = e.
    for (int e = 0; e < 64; e++) blk_a[BW-1-e*DW -: DW] = 8'(e);
    step(1'b1, blk_a, 1'b1);
    drain(80, 1'b0);

    // Backpressure with out_ready pattern 1,0,0,1.
    step(1'b1, blk_a, 1'b1);
    drain(300, 1'b1);

    // Back-to-back: A accepted, B waits in in_valid until A's last byte.
    blk_a = {64{8'hAA}};
    blk_b = {64{8'h55}};
    step(1'b1, blk_a, 1'b1);
    c = 0;
    while (!(held && elem(cur, 0) == 8'h55) && c < 80) begin
      step(1'b1, blk_b, 1'b1);
      c++;
    end
    chk("b2b_accept_cycle", 64'(c), 64'd64);
    drain(80, 1'b0);
    chk("b2b_cnt_r", 64'(r_out_block_cnt), 64'(cnt));

    // Input blocking: offer a new block from k=10 onward.
    blk_a = rand_block();
    blk_b = rand_block();
    step(1'b1, blk_a, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    c = 0;
    while (!(held && cur == blk_b) && c < 80) begin
      step(1'b1, blk_b, 1'b1);
      c++;
    end
    chk("block_accept_cycle", 64'(c), 64'd54);
    drain(80, 1'b0);

    // Asynchronous reset at k=20.
    step(1'b1, rand_block(), 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    chk("pre_reset_index", 64'(r_out_index), 64'd20);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    held = 1'b0;
    pos  = 0;
    cnt  = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b1, rand_block(), 1'b1);
    drain(80, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), rand_block(), ($urandom_range(0, 3) != 0));
    end
    drain(400, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
